// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the 5-byte serial command protocol: opcodes, frame
// sizes and the command-master state encoding.
package uart_cmd_pkg;

  localparam logic [7:0] ADDR     = 8'h01;
  localparam logic [7:0] LOAD     = 8'h02;
  localparam logic [7:0] WRITE    = 8'h03;
  localparam logic [7:0] READ     = 8'h04;
  localparam logic [7:0] READ_REQ = 8'h05;
  localparam logic [7:0] COUNT    = 8'h06;
  localparam logic [7:0] CONST    = 8'h07;

  localparam int unsigned FRAME_BYTES = 5;
  localparam int unsigned RSP_BYTES   = 5;
  localparam int unsigned DATA_BYTES  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_LO,
    ST_WAIT_HI,
    ST_RECV,
    ST_DONE
  } state_t;

endpackage

// File: rtl/uart_cmd_master.sv
// Host-side command initiator: sends opcode + 32-bit argument as 5 bytes via
// uart_tx, then gathers the 5-byte reply from uart_rx into a 32-bit result.
module uart_cmd_master #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd2_000_000,
  parameter int unsigned RSP_BYTES      = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_rcv,
  input  logic [7:0]  rx_data,
  output logic        busy
);
  import uart_cmd_pkg::*;

  localparam logic [7:0] RSP_LAST  = 8'(RSP_BYTES);
  localparam logic [7:0] DATA_LAST = 8'(DATA_BYTES);
  localparam logic [2:0] TX_LAST   = 3'(FRAME_BYTES);
  // The decision cycle and the DONE cycle use up two cycles of the budget, so
  // rsp_valid lands exactly TIMEOUT_CYCLES after the last reply strobe.
  localparam logic [31:0] TIMER_LIMIT =
      (TIMEOUT_CYCLES > 32'd2) ? TIMEOUT_CYCLES - 32'd2 : 32'd0;

  state_t      state, state_nxt;
  logic [39:0] frame;
  logic [2:0]  tx_cnt;
  logic [7:0]  rx_cnt, rx_cnt_nxt;
  logic [31:0] rsp_shift, rsp_shift_nxt;
  logic [31:0] rsp_hold;
  logic [31:0] timer;
  logic        to_flag;
  logic        rx_take;
  logic        timeout_set;

  assign tx_data     = frame[39:32];
  assign rsp_data    = (state == ST_DONE) ? rsp_shift : rsp_hold;
  assign rsp_timeout = (state == ST_DONE) && to_flag;

  // Reply bytes are taken in every non-IDLE state; early bytes can beat WAIT_HI.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    rx_take       = rx_rcv && (state != ST_IDLE);
    rx_cnt_nxt    = rx_cnt;
    rsp_shift_nxt = rsp_shift;
    if (rx_take) begin
      if (rx_cnt < DATA_LAST) rsp_shift_nxt = {rsp_shift[23:0], rx_data};
      if (rx_cnt != 8'hFF)    rx_cnt_nxt    = rx_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    busy        = 1'b1;
    tx_start    = 1'b0;
    rsp_valid   = 1'b0;
    timeout_set = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) begin
          tx_start  = 1'b1;
          state_nxt = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        if (!tx_ready) state_nxt = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (tx_ready) state_nxt = (tx_cnt == TX_LAST) ? ST_RECV : ST_SEND;
      end
      ST_RECV: begin
        if (rx_cnt_nxt >= RSP_LAST) begin
          state_nxt = ST_DONE;
        end else if (!rx_take && (timer >= TIMER_LIMIT)) begin
          state_nxt   = ST_DONE;
          timeout_set = 1'b1;
        end
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // right-hand side sees the pre-edge value regardless of statement order.
    if (rst) begin
      state     <= ST_IDLE;
      frame     <= '0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      rsp_shift <= '0;
      rsp_hold  <= '0;
      timer     <= '0;
      to_flag   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE) begin
        if (cmd_valid) begin
          frame     <= {cmd_op, cmd_arg};
          tx_cnt    <= '0;
          rx_cnt    <= '0;
          rsp_shift <= '0;
          timer     <= '0;
          to_flag   <= 1'b0;
        end
      end else begin
        rx_cnt    <= rx_cnt_nxt;
        rsp_shift <= rsp_shift_nxt;
        if ((state == ST_WAIT_LO) && !tx_ready) begin
          frame  <= {frame[31:0], 8'h00};
          tx_cnt <= tx_cnt + 3'd1;
        end
        // Timer restarts on every reply byte and on entry to RECV; saturates.
        if (rx_take || ((state == ST_WAIT_HI) && (state_nxt == ST_RECV))) begin
          timer <= '0;
        end else if (timer != 32'hFFFF_FFFF) begin
          timer <= timer + 32'd1;
        end
        if (timeout_set)       to_flag  <= 1'b1;
        if (state == ST_DONE)  rsp_hold <= rsp_shift;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Self-checking bench for uart_cmd_master with cycle-level uart_tx/uart_rx
// models, a directed vector table, random frames and hand-written corner cases.
module tb_uart_cmd_master;
  import uart_cmd_pkg::*;

  localparam int TMO    = 100;
  localparam int TX_LOW = 3;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic        rsp_valid, rsp_timeout;
  logic [31:0] rsp_data;
  logic        tx_start, tx_ready;
  logic [7:0]  tx_data;
  logic        rx_rcv;
  logic [7:0]  rx_data;
  logic        busy;

  uart_cmd_master #(.TIMEOUT_CYCLES(32'd100), .RSP_BYTES(5)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .tx_start(tx_start), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_rcv(rx_rcv), .rx_data(rx_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Driven values, applied at each falling edge by tick().
  logic        drv_rst = 1'b1, drv_valid = 1'b0;
  logic [7:0]  drv_op  = '0;
  logic [31:0] drv_arg = '0;

  // uart_tx model and reply scheduler state.
  int         cyc = 0, txm_delay = 0, txm_low = 0, txm_drop = 2;
  logic [7:0] tx_seen[$];
  logic [7:0] reply_q[$];
  bit         rx_active = 0;
  int         rx_wait = 0, reply_first_gap = 0, reply_gap = 0;
  int         strobe_cnt = 0, last_strobe = -1, fifth_cyc = -1, rst_on_strobe = -1;
  int         accepts = 0, accept_cyc = -1, first_tx_cyc = -1;
  int         rsp_pulses = 0, rsp_cyc = -1, pulse_base = 0;
  logic [31:0] got_data = '0;
  logic        got_to = 1'b0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1 time unit later.
  task automatic tick();
    @(negedge clk);
    cyc++;
    rst       = drv_rst;
    cmd_valid = drv_valid;
    cmd_op    = drv_op;
    cmd_arg   = drv_arg;
    if (txm_delay > 0) begin
      txm_delay--;
      if (txm_delay == 0) begin
        tx_ready = 1'b0;
        txm_low  = TX_LOW;
      end
    end else if (txm_low > 0) begin
      txm_low--;
      if (txm_low == 0) tx_ready = 1'b1;
    end
    rx_rcv = 1'b0;
    if (rx_active && reply_q.size() > 0) begin
      if (rx_wait == 0) begin
        rx_rcv  = 1'b1;
        rx_data = reply_q.pop_front();
        rx_wait = reply_gap;
        strobe_cnt++;
        last_strobe = cyc;
        if (strobe_cnt == 5) fifth_cyc = cyc;
        if (strobe_cnt == rst_on_strobe) rst = 1'b1;
      end else begin
        rx_wait--;
      end
    end
    #1;
    if (cmd_valid && cmd_ready && !rst) begin
      accepts++;
      accept_cyc = cyc;
    end
    if (tx_start) begin
      tx_seen.push_back(tx_data);
      if (tx_seen.size() == 1) first_tx_cyc = cyc;
      txm_delay = txm_drop;
      if (tx_seen.size() == 5) begin
        rx_active = 1;
        rx_wait   = reply_first_gap;
      end
    end
    if (rsp_valid) begin
      rsp_pulses++;
      rsp_cyc  = cyc;
      got_data = rsp_data;
      got_to   = rsp_timeout;
    end
  endtask

  task automatic prep(input logic [47:0] rep, input int n, input int fg, input int g,
                      input int drop);
    reply_q.delete();
    for (int i = 0; i < n; i++) reply_q.push_back(rep[47-8*i -: 8]);
    tx_seen.delete();
    rx_active       = 0;
    strobe_cnt      = 0;
    last_strobe     = -1;
    fifth_cyc       = -1;
    first_tx_cyc    = -1;
    rst_on_strobe   = -1;
    reply_first_gap = fg;
    reply_gap       = g;
    txm_drop        = drop;
  endtask

  // Reply semantics: first four bytes MSB first; fewer than five bytes is a timeout.
  function automatic void model(input logic [47:0] rep, input int n,
                                output logic [31:0] d, output logic to);
    d = '0;
    for (int i = 0; i < n && i < 4; i++) d = (d << 8) | 32'(rep[47-8*i -: 8]);
    to = (n < 5);
  endfunction

  function automatic logic [39:0] tx_word();
    logic [39:0] w = '0;
    for (int i = 0; i < tx_seen.size() && i < 5; i++) w = {w[31:0], tx_seen[i]};
    return w;
  endfunction

  task automatic issue(input logic [7:0] op, input logic [31:0] arg, input bit hold);
    int a0;
    a0         = accepts;
    pulse_base = rsp_pulses;
    drv_op     = op;
    drv_arg    = arg;
    drv_valid  = 1'b1;
    for (int k = 0; k < 50 && accepts == a0; k++) tick();
    check("accept", 64'(accepts - a0), 64'd1);
    if (!hold) drv_valid = 1'b0;
  endtask

  task automatic finish(input string nm, input logic [7:0] op, input logic [31:0] arg,
                        input int n, input logic [31:0] ed, input logic eto);
    for (int k = 0; k < 3000 && rsp_pulses == pulse_base; k++) tick();
    check({nm, " rsp_count"}, 64'(rsp_pulses - pulse_base), 64'd1);
    check({nm, " tx_count"}, 64'(tx_seen.size()), 64'd5);
    check({nm, " tx_bytes"}, 64'(tx_word()), 64'({op, arg}));
    check({nm, " tx_latency"}, 64'(first_tx_cyc - accept_cyc), 64'd1);
    check({nm, " rsp_data"}, 64'(got_data), 64'(ed));
    check({nm, " rsp_timeout"}, 64'(got_to), 64'(eto));
    if (!eto) check({nm, " rsp_latency"}, 64'(rsp_cyc - fifth_cyc), 64'd1);
    else if (n > 0) check({nm, " tmo_latency"}, 64'(rsp_cyc - last_strobe), 64'(TMO));
    for (int k = 0; k < 200 && reply_q.size() > 0; k++) tick();
    tick();
    tick();
    check({nm, " no_extra_rsp"}, 64'(rsp_pulses - pulse_base), 64'd1);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] arg;
    logic [47:0] rep;
    int          n, fg, gap, drop;
    logic [31:0] exp_d;
    logic        exp_to;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] ops[7];

  initial begin
    logic [31:0] ed;
    logic        eto;
    int          pb;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0;
    tx_ready = 1'b1; rx_rcv = 1'b0; rx_data = '0;

    vecs[0] = '{CONST,    32'h0000_0000, 48'h0000_0103_0000, 5,  2, 3, 2, 32'h0000_0103, 1'b0};
    vecs[1] = '{ADDR,     32'hDEAD_BEEF, 48'hDEAD_BEEF_0000, 5,  1, 2, 1, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{READ,     32'h0000_0010, 48'h1234_0000_0000, 2, 10, 5, 2, 32'h0000_1234, 1'b1};
    vecs[3] = '{WRITE,    32'h1234_5678, 48'h0A0B_0C0D_9900, 5,  0, 2, 2, 32'h0A0B_0C0D, 1'b0};
    vecs[4] = '{LOAD,     32'hCAFE_0001, 48'h1122_3344_5566, 6,  3, 4, 1, 32'h1122_3344, 1'b0};
    vecs[5] = '{READ_REQ, 32'h0000_0000, 48'h0,              0,  0, 0, 2, 32'h0000_0000, 1'b1};
    vecs[6] = '{WRITE,    32'hFFFF_FFFF, 48'hABCD_EF00_0000, 3, 12, 7, 1, 32'h00AB_CDEF, 1'b1};
    ops = '{ADDR, LOAD, WRITE, READ, READ_REQ, COUNT, CONST};

    // Reset values.
    drv_rst = 1'b1;
    repeat (3) tick();
    check("rst cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst rsp_data", 64'(rsp_data), 64'd0);
    check("rst rsp_timeout", 64'(rsp_timeout), 64'd0);
    check("rst tx_start", 64'(tx_start), 64'd0);
    check("rst tx_data", 64'(tx_data), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    drv_rst = 1'b0;
    repeat (2) tick();

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      prep(vecs[i].rep, vecs[i].n, vecs[i].fg, vecs[i].gap, vecs[i].drop);
      issue(vecs[i].op, vecs[i].arg, 1'b0);
      finish($sformatf("vec%0d", i), vecs[i].op, vecs[i].arg, vecs[i].n,
             vecs[i].exp_d, vecs[i].exp_to);
    end

    // Command held valid through a frame: next accept only right after rsp_valid.
    prep(48'hDEAD_BEEF_0000, 5, 2, 3, 2);
    issue(ADDR, 32'hDEAD_BEEF, 1'b1);
    pb = accepts;
    finish("hold", ADDR, 32'hDEAD_BEEF, 5, 32'hDEAD_BEEF, 1'b0);
    check("hold accepts", 64'(accepts - pb), 64'd1);
    check("hold accept_cycle", 64'(accept_cyc - rsp_cyc), 64'd1);
    drv_valid = 1'b0;
    pb = rsp_pulses;
    for (int k = 0; k < 3000 && rsp_pulses == pb; k++) tick();
    check("hold second rsp", 64'(rsp_pulses - pb), 64'd1);
    check("hold second timeout", 64'(got_to), 64'd1);
    check("hold second data", 64'(got_data), 64'd0);
    repeat (2) tick();

    // Stray bytes while idle are dropped.
    prep(48'hAAAA_AA00_0000, 3, 0, 1, 1);
    rx_active = 1;
    rx_wait   = 0;
    pb = rsp_pulses;
    for (int k = 0; k < 20 && reply_q.size() > 0; k++) tick();
    repeat (2) tick();
    check("stray busy", 64'(busy), 64'd0);
    check("stray no_rsp", 64'(rsp_pulses - pb), 64'd0);
    prep(48'h0000_0005_0000, 5, 2, 3, 2);
    issue(COUNT, 32'h0, 1'b0);
    finish("stray count", COUNT, 32'h0, 5, 32'h0000_0005, 1'b0);

    // Reset pulse on the 3rd reply byte abandons the frame silently.
    prep(48'h0000_0103_0000, 5, 4, 4, 2);
    rst_on_strobe = 3;
    issue(CONST, 32'h0, 1'b0);
    for (int k = 0; k < 400 && strobe_cnt < 3; k++) tick();
    check("midrst reached", 64'(strobe_cnt), 64'd3);
    tick();
    check("midrst cmd_ready", 64'(cmd_ready), 64'd1);
    check("midrst busy", 64'(busy), 64'd0);
    repeat (40) tick();
    check("midrst no_rsp", 64'(rsp_pulses - pulse_base), 64'd0);
    prep(48'h0000_0103_0000, 5, 2, 3, 2);
    issue(CONST, 32'h0, 1'b0);
    finish("midrst const", CONST, 32'h0, 5, 32'h0000_0103, 1'b0);

    // Random frames against the reply model.
    for (int it = 0; it < 20; it++) begin
      logic [7:0]  op;
      logic [31:0] arg;
      logic [47:0] rep;
      int          r, n, fg;
      op  = ops[$urandom_range(0, 6)];
      arg = $urandom;
      rep = {16'($urandom), 32'($urandom)};
      r   = $urandom_range(0, 9);
      n   = (r < 7) ? 5 + (r % 2) : r - 6;
      fg  = (n >= 5) ? $urandom_range(0, 4) : $urandom_range(10, 14);
      model(rep, n, ed, eto);
      prep(rep, n, fg, $urandom_range(3, 12), $urandom_range(1, 2));
      issue(op, arg, 1'b0);
      finish($sformatf("rand%0d", it), op, arg, n, ed, eto);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
